// File: rtl/denise_bplshifter.sv
// Bitplane shifter: eight plane holding/shift registers with per-parity scroll delay lines,
// producing the registered colour select vector for the HAM/CLUT stage.
module denise_bplshifter #(
    parameter logic [8:0] BPLDAT_BASE = 9'h110
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk7_en,
    input  logic [8:1]  reg_address_in,
    input  logic [15:0] data_in,
    input  logic        hires,
    input  logic        shres,
    input  logic [3:0]  nplanes,
    input  logic [3:0]  scroll_odd,
    input  logic [3:0]  scroll_even,
    output logic [7:0]  select,
    output logic        active
);

    logic [15:0] hold_q  [8];
    logic [15:0] shift_q [8];
    logic [63:0] dly_q   [8];
    logic        load_pending;
    logic [4:0]  bit_cnt;
    logic [1:0]  phase;
    logic        shift_en;
    logic        wr_hit;
    logic [2:0]  wr_idx;
    logic [5:0]  tap_odd;
    logic [5:0]  tap_even;
    logic [5:0]  tap_sel;
    logic [7:0]  pix;
    logic [7:0]  sel_d;

    assign wr_hit = clk7_en && (reg_address_in[8:4] == BPLDAT_BASE[8:4]);
    assign wr_idx = reg_address_in[3:1];
    assign active = (bit_cnt != 5'd0);

    always_comb begin
        if (shres)
            shift_en = 1'b1;
        else if (hires)
            shift_en = (phase == 2'd0) || (phase == 2'd2);
        else
            shift_en = clk7_en;
    end

    // phase 0 lines up with the next clk7_en, so hires shifts at lores edge and midway
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            phase <= 2'd0;
        else if (clk7_en)
            phase <= 2'd1;
        else
            phase <= phase + 2'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++)
                hold_q[i] <= '0;
        end else if (wr_hit) begin
            hold_q[wr_idx] <= data_in;
        end
    end

    // a BPL1DAT write on a load cycle re-arms for the following shift slot
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            load_pending <= 1'b0;
        else if (wr_hit && (wr_idx == 3'd0))
            load_pending <= 1'b1;
        else if (shift_en)
            load_pending <= 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++)
                shift_q[i] <= '0;
            bit_cnt <= 5'd0;
        end else if (shift_en) begin
            if (load_pending) begin
                for (int i = 0; i < 8; i++)
                    shift_q[i] <= hold_q[i];
                bit_cnt <= 5'd16;
            end else begin
                for (int i = 0; i < 8; i++)
                    shift_q[i] <= {shift_q[i][14:0], 1'b0};
                if (bit_cnt != 5'd0)
                    bit_cnt <= bit_cnt - 5'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++)
                dly_q[i] <= '0;
        end else if (shift_en) begin
            for (int i = 0; i < 8; i++)
                dly_q[i] <= {dly_q[i][62:0], shift_q[i][15]};
        end
    end

    // scroll is in lores pixels; scale to the current shift rate
    always_comb begin
        tap_odd  = '0;
        tap_even = '0;
        tap_sel  = '0;
        pix      = '0;
        sel_d    = '0;
        if (shres) begin
            tap_odd  = {scroll_odd, 2'b00};
            tap_even = {scroll_even, 2'b00};
        end else if (hires) begin
            tap_odd  = {1'b0, scroll_odd, 1'b0};
            tap_even = {1'b0, scroll_even, 1'b0};
        end else begin
            tap_odd  = {2'b00, scroll_odd};
            tap_even = {2'b00, scroll_even};
        end
        for (int i = 0; i < 8; i++) begin
            tap_sel = (i % 2 == 1) ? tap_even : tap_odd;
            if (tap_sel == 6'd0)
                pix[i] = shift_q[i][15];
            else
                pix[i] = dly_q[i][tap_sel - 6'd1];
            sel_d[i] = pix[i] && (nplanes > 4'(i));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            select <= 8'h00;
        else
            select <= sel_d;
    end

endmodule
